// File: rtl/mod_cnt_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : mod_cnt_pkg                                                |
// | Desc    : Shared constants and helpers for the modulo-N counter.     |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package mod_cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int c_DEFAULT_WIDTH = 5;

  // Operates on 16 bits so any legal WIDTH (2..16) fits after zero-extension.
  function automatic logic [15:0] clip(input logic [15:0] val, input logic [15:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter.sv
// +----------------------------------------------------------------------+
// | Module  : mod_n_counter                                              |
// | Desc    : Run-time programmable up/down modulo counter, 0..max_val,  |
// |           with load, registered tc and chainable carry.              |
// |           Optional wrap counter: define MOD_N_COUNTER_WRAPCNT_EN.    |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module mod_n_counter
  import mod_cnt_pkg::*;
#(
  parameter int WIDTH   = c_DEFAULT_WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_N_COUNTER_WRAPCNT_EN
  input  logic             wrap_clr,
  output logic [15:0]      wrap_cnt,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry
);

  localparam logic [WIDTH-1:0] c_RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic [WIDTH-1:0] w_load_clip;

  assign w_load_clip = WIDTH'(clip(16'(load_val), 16'(max_val)));

  always_comb begin
    w_q_nxt  = r_q;
    w_tc_nxt = 1'b0;
    if (load) begin
      w_q_nxt = w_load_clip;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        // ">=" rather than "==" so a lowered limit still wraps cleanly.
        if (r_q >= max_val) begin
          w_q_nxt  = '0;
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q + WIDTH'(1);
        end
      end else begin
        if (r_q == '0) begin
          w_q_nxt  = max_val;
          w_tc_nxt = 1'b1;
        end else if (r_q > max_val) begin
          w_q_nxt = max_val;
        end else begin
          w_q_nxt = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= c_RST_Q;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_tc <= w_tc_nxt;
    end
  end

`ifdef MOD_N_COUNTER_WRAPCNT_EN
  logic [15:0] r_wrap_cnt;

  // Clear beats a coincident wrap; count saturates instead of rolling over.
  always_ff @(posedge clk) begin
    if (rst || wrap_clr) begin
      r_wrap_cnt <= '0;
    end else if (w_tc_nxt && (r_wrap_cnt != 16'hFFFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 16'd1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

  assign q     = r_q;
  assign tc    = r_tc;
  assign carry = en & ((up_dn == DIR_DN) ? (r_q == '0) : (r_q >= max_val));

endmodule

`default_nettype wire

// File: tb/tb_mod_n_counter.sv
// +----------------------------------------------------------------------+
// | Module  : tb_mod_n_counter                                           |
// | Desc    : Scoreboard bench for mod_n_counter, incl. two-stage chain. |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mod_n_counter;

  localparam int         c_W   = 5;
  localparam logic [4:0] c_RST = 5'd3;

  typedef struct {
    logic [4:0]  q;
    logic        tc;
    logic        carry;
    logic [15:0] wc;
  } exp_t;

  exp_t sb[$];
  int   sb_c[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0, wrap_clr = 1'b0;
  logic [4:0] max_val = 5'd0, load_val = 5'd0;
  logic [4:0] q;
  logic       tc, carry, carry_obs;
  logic [15:0] wrap_cnt;

  logic       c_rst = 1'b0, c_en = 1'b0;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c1_tc, c0_carry, c1_carry;

  // model state
  logic [4:0]  m_q  = 'x;
  logic [15:0] m_wc = 16'd0;

  always #5 clk = ~clk;

  mod_n_counter #(.WIDTH(c_W), .RST_VAL(int'(c_RST))) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .max_val(max_val),
    .load(load), .load_val(load_val),
`ifdef MOD_N_COUNTER_WRAPCNT_EN
    .wrap_clr(wrap_clr), .wrap_cnt(wrap_cnt),
`endif
    .q(q), .tc(tc), .carry(carry)
  );

`ifndef MOD_N_COUNTER_WRAPCNT_EN
  assign wrap_cnt = 16'd0;
`endif

  mod_n_counter #(.WIDTH(4), .RST_VAL(0)) c0 (
    .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .max_val(4'd9),
    .load(1'b0), .load_val(4'd0),
`ifdef MOD_N_COUNTER_WRAPCNT_EN
    .wrap_clr(1'b0), .wrap_cnt(),
`endif
    .q(c0_q), .tc(c0_tc), .carry(c0_carry)
  );

  mod_n_counter #(.WIDTH(4), .RST_VAL(0)) c1 (
    .clk(clk), .rst(c_rst), .en(c0_carry), .up_dn(1'b1), .max_val(4'd9),
    .load(1'b0), .load_val(4'd0),
`ifdef MOD_N_COUNTER_WRAPCNT_EN
    .wrap_clr(1'b0), .wrap_cnt(),
`endif
    .q(c1_q), .tc(c1_tc), .carry(c1_carry)
  );

  // Drives one cycle, predicts the post-edge result and queues it.
  task automatic drive(input logic r, input logic l, input logic e, input logic u,
                       input logic [4:0] mx, input logic [4:0] lv, input logic clr);
    exp_t       x;
    logic [4:0] nq;
    logic       ntc;
    @(negedge clk);
    rst = r; load = l; en = e; up_dn = u; max_val = mx; load_val = lv; wrap_clr = clr;
    #1;
    carry_obs = carry;
    x.carry = e & (u ? (m_q >= mx) : (m_q == 5'd0));
    nq = m_q; ntc = 1'b0;
    if (r) nq = c_RST;
    else if (l) nq = (lv > mx) ? mx : lv;
    else if (e) begin
      if (u) begin
        if (m_q >= mx) begin nq = 5'd0; ntc = 1'b1; end
        else nq = m_q + 5'd1;
      end else begin
        if (m_q == 5'd0) begin nq = mx; ntc = 1'b1; end
        else if (m_q > mx) nq = mx;
        else nq = m_q - 5'd1;
      end
    end
    if (r || clr) m_wc = 16'd0;
    else if (ntc && m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
    m_q = nq;
    x.q = nq; x.tc = ntc; x.wc = m_wc;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    repeat (2) begin
      drive(1, 0, 0, 1, 5'd29, 5'd0, 0);
      x = sb.pop_front(); n_chk++;
      if ({q, tc, carry_obs} !== {x.q, x.tc, x.carry}) begin
        n_fail++;
        $display("FAIL reset: q=%0d tc=%0b carry=%0b, expected q=%0d tc=%0b carry=%0b",
                 q, tc, carry_obs, x.q, x.tc, x.carry);
      end
    end
  endtask

  task automatic test_mod30_up();
    exp_t x;
    drive(0, 1, 0, 1, 5'd29, 5'd0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 1, 1, 5'd29, 5'd0, 0);
      x = sb.pop_front(); n_chk++;
      if ({q, tc, carry_obs} !== {x.q, x.tc, x.carry}) begin
        n_fail++;
        $display("FAIL mod30_up[%0d]: q=%0d tc=%0b carry=%0b, expected q=%0d tc=%0b carry=%0b",
                 i, q, tc, carry_obs, x.q, x.tc, x.carry);
      end
    end
  endtask

  task automatic test_down_wrap();
    exp_t x;
    drive(0, 1, 1, 0, 5'd29, 5'd0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 5'd29, 5'd0, 0);
      x = sb.pop_front(); n_chk++;
      if ({q, tc, carry_obs} !== {x.q, x.tc, x.carry}) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: q=%0d tc=%0b carry=%0b, expected q=%0d tc=%0b carry=%0b",
                 i, q, tc, carry_obs, x.q, x.tc, x.carry);
      end
    end
  endtask

  task automatic test_load_clip();
    exp_t x;
    drive(0, 1, 1, 1, 5'd29, 5'd31, 0);
    x = sb.pop_front(); n_chk++;
    if ({q, tc} !== {x.q, x.tc} || q !== 5'd29) begin
      n_fail++;
      $display("FAIL load_clip: q=%0d tc=%0b, expected q=%0d tc=%0b", q, tc, x.q, x.tc);
    end
    drive(1, 1, 1, 1, 5'd29, 5'd31, 0);
    x = sb.pop_front(); n_chk++;
    if ({q, tc} !== {x.q, x.tc}) begin
      n_fail++;
      $display("FAIL load_vs_rst: q=%0d tc=%0b, expected q=%0d tc=%0b", q, tc, x.q, x.tc);
    end
  endtask

  task automatic test_limit_lowered();
    exp_t x;
    for (int d = 0; d < 2; d++) begin
      drive(0, 1, 0, 1, 5'd29, 5'd20, 0);
      void'(sb.pop_front());
      drive(0, 0, 1, (d == 0), 5'd9, 5'd0, 0);
      x = sb.pop_front(); n_chk++;
      if ({q, tc, carry_obs} !== {x.q, x.tc, x.carry}) begin
        n_fail++;
        $display("FAIL limit_lowered dir=%0d: q=%0d tc=%0b carry=%0b, expected q=%0d tc=%0b carry=%0b",
                 d, q, tc, carry_obs, x.q, x.tc, x.carry);
      end
    end
  endtask

  task automatic test_hold_reset();
    exp_t x;
    drive(0, 1, 0, 1, 5'd29, 5'd17, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(i == 5, 0, 0, 1, 5'd29, 5'd0, 0);
      x = sb.pop_front(); n_chk++;
      if ({q, tc, carry_obs} !== {x.q, x.tc, x.carry}) begin
        n_fail++;
        $display("FAIL hold_reset[%0d]: q=%0d tc=%0b carry=%0b, expected q=%0d tc=%0b carry=%0b",
                 i, q, tc, carry_obs, x.q, x.tc, x.carry);
      end
    end
  endtask

  task automatic test_boundaries();
    exp_t x;
    // divide-by-1 in both directions, then full binary wrap both ways
    for (int i = 0; i < 8; i++) begin
      logic [4:0] mx;
      mx = (i < 4) ? 5'd0 : 5'd31;
      if (i == 4) begin drive(0, 1, 0, 1, mx, 5'd31, 0); void'(sb.pop_front()); end
      drive(0, 0, 1, i[0], mx, 5'd0, 0);
      x = sb.pop_front(); n_chk++;
      if ({q, tc, carry_obs} !== {x.q, x.tc, x.carry}) begin
        n_fail++;
        $display("FAIL boundary[%0d]: q=%0d tc=%0b carry=%0b, expected q=%0d tc=%0b carry=%0b",
                 i, q, tc, carry_obs, x.q, x.tc, x.carry);
      end
    end
  endtask

  task automatic test_random();
    exp_t x;
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            1'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom),
            5'($urandom), 0);
      x = sb.pop_front(); n_chk++;
      if ({q, tc, carry_obs} !== {x.q, x.tc, x.carry}) begin
        n_fail++;
        $display("FAIL random[%0d]: q=%0d tc=%0b carry=%0b, expected q=%0d tc=%0b carry=%0b",
                 i, q, tc, carry_obs, x.q, x.tc, x.carry);
      end
    end
  endtask

`ifdef MOD_N_COUNTER_WRAPCNT_EN
  task automatic test_wrapcnt();
    exp_t x;
    drive(0, 0, 0, 1, 5'd2, 5'd0, 1);
    void'(sb.pop_front());
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 1, 5'd2, 5'd0, i == 8);
      x = sb.pop_front(); n_chk++;
      if (wrap_cnt !== x.wc) begin
        n_fail++;
        $display("FAIL wrapcnt[%0d]: wrap_cnt=%0d, expected %0d", i, wrap_cnt, x.wc);
      end
    end
  endtask
`endif

  task automatic test_cascade();
    int tc1_seen;
    int exp_v;
    @(negedge clk); c_rst = 1'b1; c_en = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (c0_q !== 4'd0 || c1_q !== 4'd0) begin
      n_fail++;
      $display("FAIL cascade_reset: count=%0d%0d, expected 00", c1_q, c0_q);
    end
    tc1_seen = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk); c_rst = 1'b0; c_en = 1'b1;
      sb_c.push_back(i % 100);
      @(posedge clk); #1;
      exp_v = sb_c.pop_front(); n_chk++;
      if (c0_q > 4'd9 || c1_q > 4'd9 || (int'(c1_q) * 10 + int'(c0_q)) != exp_v) begin
        n_fail++;
        $display("FAIL cascade[%0d]: count=%0d%0d, expected %0d", i, c1_q, c0_q, exp_v);
      end
      if (c1_tc === 1'b1) tc1_seen++;
    end
    @(negedge clk); c_en = 1'b0;
    n_chk++;
    if (tc1_seen != 1) begin
      n_fail++;
      $display("FAIL cascade_wraps: stage-1 tc pulses=%0d, expected 1", tc1_seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mod30_up();
    test_down_wrap();
    test_load_clip();
    test_limit_lowered();
    test_hold_reset();
    test_boundaries();
    test_random();
`ifdef MOD_N_COUNTER_WRAPCNT_EN
    test_wrapcnt();
`endif
    test_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
